fetch_unit: RTL and testbench

- Front end of the pipelined CPU. Generates the PC and reads 32-bit instructions from combinational instruction memory.
- Buffers {pc, instruction} pairs in a small FIFO and hands them to the decode/control stage through a valid/ready handshake.
- Takes the redirect (taken branch target) back from decode and flushes all wrong-path entries.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch front end (fetch_unit, fetch_fifo).
package fetch_pkg;

    localparam int INSTR_W    = 32;
    localparam int PC_STEP    = 4;
    localparam int ENTRY_PC_W = 64;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

    function automatic logic [ENTRY_PC_W-1:0] align_pc(input logic [ENTRY_PC_W-1:0] addr);
        return addr & ~ENTRY_PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push and pop, and pops on empty are ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            if (do_push) begin
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; the top zeroes its outputs whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i && do_push) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[head_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, fetch queue and redirect flush.
// Optional macro FETCH_BYPASS_EN lets decode take the current fetch directly when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    logic [ADDR_W-1:0]        pc_q, pc_d;
    logic                     push;
    logic                     pop;
    logic                     bypass_take;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    fetch_entry_t             fifo_wdata;
    fetch_entry_t             fifo_head;
    logic [ENTRY_PC_W-1:0]    target_pc;

    assign imem_addr  = pc_q;
    assign fifo_wdata = '{pc: ENTRY_PC_W'(pc_q), instr: imem_rdata};
    assign target_pc  = align_pc(ENTRY_PC_W'(redirect_pc));

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .flush_i (redirect),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Outputs are forced to zero during reset so nothing undefined leaks out before the first edge.
    always_comb begin
        pop         = instr_ready && !fifo_empty && !reset;
        bypass_take = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        occupancy   = '0;
        if (!reset) begin
            occupancy = fifo_count;
            if (!fifo_empty) begin
                instr_valid = 1'b1;
                instr       = fifo_head.instr;
                instr_pc    = fifo_head.pc[ADDR_W-1:0];
            end
`ifdef FETCH_BYPASS_EN
            else if (!redirect) begin
                instr_valid = 1'b1;
                instr       = imem_rdata;
                instr_pc    = pc_q;
                bypass_take = instr_ready;
            end
`endif
        end
        push = !reset && !redirect && !bypass_take && (!fifo_full || pop);
        pc_d = pc_q;
        if (redirect) begin
            pc_d = target_pc[ADDR_W-1:0];
        end else if (push || bypass_take) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, randomized run against a queue model.
module tb_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] CONST_WORD = 32'h91000421;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic [2:0]  occupancy;

    int testsRun    = 0;
    int testsFailed = 0;
    bit constMode   = 1'b1;

    logic [63:0] mPc;
    logic [63:0] qPc[$];
    logic [31:0] qIn[$];

    typedef struct {
        logic        rst;
        logic        redir;
        logic [63:0] rpc;
        logic        rdy;
        logic        expValid;
        logic [63:0] expPc;
        logic [63:0] expAddr;
        int          expOcc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .occupancy   (occupancy)
    );

    function automatic logic [31:0] imemWord(input logic [63:0] a);
        if (constMode) return CONST_WORD;
        return (a[33:2] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
    endfunction

    always_comb imem_rdata = imemWord(imem_addr);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy);
        reset       = rst;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
    endtask

    task automatic checkModel();
        logic        ev;
        logic [31:0] ei;
        logic [63:0] ep;
        int          eo;
        ev = 1'b0;
        ei = '0;
        ep = '0;
        eo = 0;
        if (!reset) begin
            eo = qPc.size();
            if (qPc.size() > 0) begin
                ev = 1'b1;
                ei = qIn[0];
                ep = qPc[0];
            end
`ifdef FETCH_BYPASS_EN
            else if (!redirect) begin
                ev = 1'b1;
                ei = imemWord(mPc);
                ep = mPc;
            end
`endif
        end
        checkOutput("model imem_addr", imem_addr, mPc);
        checkOutput("model instr_valid", 64'(instr_valid), 64'(ev));
        checkOutput("model instr", 64'(instr), 64'(ei));
        checkOutput("model instr_pc", instr_pc, ep);
        checkOutput("model occupancy", 64'(occupancy), 64'(eo));
    endtask

    task automatic modelEdge();
        int sz;
        bit popIt;
        bit take;
        if (reset) begin
            qPc.delete();
            qIn.delete();
            mPc = RESET_PC;
        end else if (redirect) begin
            qPc.delete();
            qIn.delete();
            mPc = redirect_pc & ~64'h3;
        end else begin
            sz    = qPc.size();
            popIt = (sz > 0) && instr_ready;
            take  = 1'b0;
`ifdef FETCH_BYPASS_EN
            take  = (sz == 0) && instr_ready;
`endif
            if (popIt) begin
                void'(qPc.pop_front());
                void'(qIn.pop_front());
            end
            if (take) begin
                mPc = mPc + 64'd4;
            end else if (sz < DEPTH || popIt) begin
                qPc.push_back(mPc);
                qIn.push_back(imemWord(mPc));
                mPc = mPc + 64'd4;
            end
        end
    endtask

    task automatic endCycle();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addVec(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy,
                          input logic ev, input logic [63:0] ep, input logic [63:0] ea, input int eo);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.expValid = ev; v.expPc = ep; v.expAddr = ea; v.expOcc = eo;
        vecs.push_back(v);
    endtask

    task automatic checkDirect(input string tag, input logic ev, input logic [63:0] ep,
                               input logic [63:0] ea, input int eo);
        checkOutput({tag, " instr_valid"}, 64'(instr_valid), 64'(ev));
        checkOutput({tag, " instr"}, 64'(instr), ev ? 64'(CONST_WORD) : 64'h0);
        checkOutput({tag, " instr_pc"}, instr_pc, ep);
        checkOutput({tag, " imem_addr"}, imem_addr, ea);
        checkOutput({tag, " occupancy"}, 64'(occupancy), 64'(eo));
    endtask

    initial begin
        int bias;
        logic rr;
        logic rd;
        logic [63:0] rp;
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        endCycle();

`ifndef FETCH_BYPASS_EN
        // rst redir rpc rdy | valid instr_pc imem_addr occupancy
        addVec(1, 0, 64'h0,   1, 0, 64'h0,   64'h0,   0);
        addVec(0, 0, 64'h0,   1, 0, 64'h0,   64'h0,   0);
        addVec(0, 0, 64'h0,   1, 1, 64'h0,   64'h4,   1);
        addVec(0, 0, 64'h0,   1, 1, 64'h4,   64'h8,   1);
        addVec(0, 0, 64'h0,   1, 1, 64'h8,   64'hC,   1);
        addVec(1, 0, 64'h0,   0, 0, 64'h0,   64'h10,  0);
        addVec(0, 0, 64'h0,   0, 0, 64'h0,   64'h0,   0);
        addVec(0, 0, 64'h0,   0, 1, 64'h0,   64'h4,   1);
        addVec(0, 0, 64'h0,   0, 1, 64'h0,   64'h8,   2);
        addVec(0, 0, 64'h0,   0, 1, 64'h0,   64'hC,   3);
        addVec(0, 0, 64'h0,   0, 1, 64'h0,   64'h10,  4);
        addVec(0, 0, 64'h0,   0, 1, 64'h0,   64'h10,  4);
        addVec(0, 0, 64'h0,   1, 1, 64'h0,   64'h10,  4);
        addVec(0, 0, 64'h0,   0, 1, 64'h4,   64'h14,  4);
        addVec(0, 1, 64'h103, 0, 1, 64'h4,   64'h14,  4);
        addVec(0, 0, 64'h0,   1, 0, 64'h0,   64'h100, 0);
        addVec(0, 0, 64'h0,   1, 1, 64'h100, 64'h104, 1);
        addVec(0, 1, 64'h200, 1, 1, 64'h104, 64'h108, 1);
        addVec(0, 0, 64'h0,   1, 0, 64'h0,   64'h200, 0);
        addVec(0, 0, 64'h0,   0, 1, 64'h200, 64'h204, 1);
        addVec(0, 0, 64'h0,   0, 1, 64'h200, 64'h208, 2);
        addVec(1, 0, 64'h0,   0, 0, 64'h0,   64'h20C, 0);
        addVec(0, 0, 64'h0,   0, 0, 64'h0,   64'h0,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            checkDirect($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expAddr, vecs[i].expOcc);
            endCycle();
        end

        // Back-to-back redirects: only the second target survives.
        applyStimulus(1'b0, 1'b1, 64'h300, 1'b1);
        endCycle();
        applyStimulus(1'b0, 1'b1, 64'h407, 1'b1);
        checkDirect("b2b first", 1'b0, 64'h0, 64'h300, 0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkDirect("b2b second", 1'b0, 64'h0, 64'h404, 0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkDirect("b2b head", 1'b1, 64'h404, 64'h408, 1);
        endCycle();

        // PC wrap at the top of the address space.
        applyStimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        checkDirect("wrap top", 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        checkDirect("wrap zero", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1);
        endCycle();
`else
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkDirect("bypass first", 1'b1, 64'h0, 64'h0, 0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        checkDirect("bypass next", 1'b1, 64'h4, 64'h4, 0);
        endCycle();
`endif

        constMode = 1'b0;
        applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
        checkModel();
        endCycle();
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       bias = 10;
                    1:       bias = 50;
                    default: bias = 90;
                endcase
            end
            rr = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rp = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            end else begin
                rp = {$urandom, $urandom};
            end
            applyStimulus(rr, rd, rp, ($urandom_range(0, 99) < bias));
            checkModel();
            endCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
